// File: rtl/rr_burst_xfer_if.sv
// Bundle between the 4-way arbiter/requesters and the burst transfer stage.
// The master side is the transfer stage itself; the slave side is its environment.
interface rr_burst_xfer_if #(
  parameter int DW = 8
);
  logic [3:0]      gnt;
  logic [4*DW-1:0] data_in;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      beat_take;
  logic [3:0]      done;
  logic [1:0]      owner;
  logic            busy;
  logic            err;

  modport master (
    input  gnt, data_in, out_ready,
    output out_data, out_valid, beat_take, done, owner, busy, err
  );

  modport slave (
    output gnt, data_in, out_ready,
    input  out_data, out_valid, beat_take, done, owner, busy, err
  );
endinterface

// File: rtl/rr_burst_xfer.sv
// Locks onto the arbiter's one-hot grant and moves a BURST-beat transfer from the
// granted requester onto one valid/ready channel, then pulses that requester's done.
module rr_burst_xfer #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  rr_burst_xfer_if.master bus
);
  localparam int            CW   = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE, COOL} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [1:0]    owner;
  logic          out_valid;
  logic [3:0]    done;
  logic          busy;
  logic          err;

  logic          hs;
  logic          gnt_onehot;
  logic [1:0]    gnt_idx;

  always_comb begin
    gnt_onehot = (bus.gnt != 4'b0000) && ((bus.gnt & (bus.gnt - 4'd1)) == 4'b0000);
    gnt_idx    = 2'd0;
    case (bus.gnt)
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

  assign hs = out_valid & bus.out_ready;

  // COOL absorbs the arbiter's stale grant for the requester that just finished.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      owner     <= 2'd0;
      out_valid <= 1'b0;
      done      <= 4'b0000;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_onehot) begin
            owner     <= gnt_idx;
            count     <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= XFER;
          end else if (bus.gnt != 4'b0000) begin
            err <= 1'b1;
          end
        end
        XFER: begin
          if (hs) begin
            count <= count + 1'b1;
            if (count == LAST) begin
              out_valid <= 1'b0;
              done      <= 4'b0001 << owner;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 4'b0000;
          state <= COOL;
        end
        COOL: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_data  = bus.data_in[owner*DW +: DW];
  assign bus.out_valid = out_valid;
  assign bus.beat_take = hs ? (4'b0001 << owner) : 4'b0000;
  assign bus.done      = done;
  assign bus.owner     = owner;
  assign bus.busy      = busy;
  assign bus.err       = err;
endmodule

// File: tb/tb_rr_burst_xfer.sv
// Directed bench for rr_burst_xfer: vector table plus reset, arbiter-chain and
// single-beat sequences. Requesters step their data on beat_take.
module tb_rr_burst_xfer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_burst_xfer_if #(.DW(8)) bus ();
  rr_burst_xfer_if #(.DW(8)) bus1 ();

  rr_burst_xfer #(.DW(8), .BURST(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  rr_burst_xfer #(.DW(8), .BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks   = 0;
  int failures = 0;

  // Requester data model: slice i = base_i + beats taken so far
  logic [7:0] idx [4];
  logic       idx_clr = 1'b1;
  assign bus.data_in = {8'hB0 + idx[3], 8'hA0 + idx[2], 8'h90 + idx[1], 8'h80 + idx[0]};

  // Round-robin arbiter model, holds grant while the owner's request stays high
  logic       arb_en = 1'b0;
  logic [3:0] arb_gnt, man_gnt, req_r, req, ng;
  int         last, nl;
  assign req     = req_r & ~bus.done;
  assign bus.gnt = arb_en ? arb_gnt : man_gnt;

  always @(posedge clk) begin
    if (idx_clr) begin
      for (int i = 0; i < 4; i++) idx[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) if (bus.beat_take[i]) idx[i] <= idx[i] + 8'h01;
    end
    if (!arb_en) begin
      arb_gnt <= 4'b0000;
      last    <= 3;
      req_r   <= 4'hF;
    end else begin
      for (int i = 0; i < 4; i++) if (bus.done[i]) req_r[i] <= 1'b0;
      if ((arb_gnt & req) == 4'b0000) begin
        ng = 4'b0000;
        nl = last;
        for (int k = 1; k <= 4; k++) begin
          if (ng == 4'b0000 && req[(last + k) % 4]) begin
            ng[(last + k) % 4] = 1'b1;
            nl = (last + k) % 4;
          end
        end
        arb_gnt <= ng;
        last    <= nl;
      end
    end
  end

  typedef struct {
    logic [3:0] gnt;
    logic       rdy;
    logic       v;
    logic [7:0] d;
    logic [3:0] t;
    logic [3:0] dn;
    logic [1:0] o;
    logic       b;
    logic       e;
  } vec_t;

  vec_t vt [35];

  function automatic vec_t mk(input logic [3:0] g, input logic r, input logic v,
                              input logic [7:0] d, input logic [3:0] t, input logic [3:0] dn,
                              input logic [1:0] o, input logic b, input logic e);
    vec_t x;
    x.gnt = g; x.rdy = r; x.v = v; x.d = d; x.t = t; x.dn = dn; x.o = o; x.b = b; x.e = e;
    return x;
  endfunction

  function automatic logic [31:0] pk_vec(input vec_t x);
    return {11'b0, x.v, x.d, x.t, x.dn, x.o, x.b, x.e};
  endfunction

  function automatic logic [31:0] pk_dut();
    return {11'b0, bus.out_valid, bus.out_data, bus.beat_take, bus.done, bus.owner, bus.busy, bus.err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int         order    [4];
  int         done_cyc [4];
  int         beats    [4];
  int         ndone;

  initial begin
    man_gnt        = 4'b0000;
    bus.out_ready  = 1'b1;
    bus1.gnt       = 4'b0000;
    bus1.out_ready = 1'b1;
    bus1.data_in   = 32'h44332211;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", pk_dut(), {11'b0, 1'b0, 8'h80, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0});
    @(negedge clk);
    rst     = 1'b1;
    idx_clr = 1'b0;

    // Single grant, backpressure with grant changes, illegal grant, sticky err
    vt[0]  = mk(4'b0100, 1, 0, 8'h80, 4'h0, 4'h0, 2'd0, 0, 0);
    vt[1]  = mk(4'b0000, 1, 1, 8'hA0, 4'h4, 4'h0, 2'd2, 1, 0);
    vt[2]  = mk(4'b0000, 1, 1, 8'hA1, 4'h4, 4'h0, 2'd2, 1, 0);
    vt[3]  = mk(4'b0000, 1, 1, 8'hA2, 4'h4, 4'h0, 2'd2, 1, 0);
    vt[4]  = mk(4'b0000, 1, 1, 8'hA3, 4'h4, 4'h0, 2'd2, 1, 0);
    vt[5]  = mk(4'b0000, 1, 0, 8'hA4, 4'h0, 4'h4, 2'd2, 1, 0);
    vt[6]  = mk(4'b0000, 1, 0, 8'hA4, 4'h0, 4'h0, 2'd2, 1, 0);
    vt[7]  = mk(4'b0001, 0, 0, 8'hA4, 4'h0, 4'h0, 2'd2, 0, 0);
    vt[8]  = mk(4'b1000, 1, 1, 8'h80, 4'h1, 4'h0, 2'd0, 1, 0);
    vt[9]  = mk(4'b1000, 0, 1, 8'h81, 4'h0, 4'h0, 2'd0, 1, 0);
    vt[10] = mk(4'b1000, 0, 1, 8'h81, 4'h0, 4'h0, 2'd0, 1, 0);
    vt[11] = mk(4'b1000, 1, 1, 8'h81, 4'h1, 4'h0, 2'd0, 1, 0);
    vt[12] = mk(4'b1000, 1, 1, 8'h82, 4'h1, 4'h0, 2'd0, 1, 0);
    vt[13] = mk(4'b1000, 0, 1, 8'h83, 4'h0, 4'h0, 2'd0, 1, 0);
    vt[14] = mk(4'b1000, 1, 1, 8'h83, 4'h1, 4'h0, 2'd0, 1, 0);
    vt[15] = mk(4'b1000, 1, 0, 8'h84, 4'h0, 4'h1, 2'd0, 1, 0);
    vt[16] = mk(4'b1000, 1, 0, 8'h84, 4'h0, 4'h0, 2'd0, 1, 0);
    vt[17] = mk(4'b1000, 0, 0, 8'h84, 4'h0, 4'h0, 2'd0, 0, 0);
    vt[18] = mk(4'b0000, 0, 1, 8'hB0, 4'h0, 4'h0, 2'd3, 1, 0);
    vt[19] = mk(4'b0000, 1, 1, 8'hB0, 4'h8, 4'h0, 2'd3, 1, 0);
    vt[20] = mk(4'b0000, 1, 1, 8'hB1, 4'h8, 4'h0, 2'd3, 1, 0);
    vt[21] = mk(4'b0000, 1, 1, 8'hB2, 4'h8, 4'h0, 2'd3, 1, 0);
    vt[22] = mk(4'b0000, 1, 1, 8'hB3, 4'h8, 4'h0, 2'd3, 1, 0);
    vt[23] = mk(4'b0110, 1, 0, 8'hB4, 4'h0, 4'h8, 2'd3, 1, 0);
    vt[24] = mk(4'b0110, 1, 0, 8'hB4, 4'h0, 4'h0, 2'd3, 1, 0);
    vt[25] = mk(4'b0110, 1, 0, 8'hB4, 4'h0, 4'h0, 2'd3, 0, 0);
    vt[26] = mk(4'b0000, 1, 0, 8'hB4, 4'h0, 4'h0, 2'd3, 0, 1);
    vt[27] = mk(4'b0010, 1, 0, 8'hB4, 4'h0, 4'h0, 2'd3, 0, 1);
    vt[28] = mk(4'b0000, 1, 1, 8'h90, 4'h2, 4'h0, 2'd1, 1, 1);
    vt[29] = mk(4'b0000, 1, 1, 8'h91, 4'h2, 4'h0, 2'd1, 1, 1);
    vt[30] = mk(4'b0000, 1, 1, 8'h92, 4'h2, 4'h0, 2'd1, 1, 1);
    vt[31] = mk(4'b0000, 1, 1, 8'h93, 4'h2, 4'h0, 2'd1, 1, 1);
    vt[32] = mk(4'b0000, 1, 0, 8'h94, 4'h0, 4'h2, 2'd1, 1, 1);
    vt[33] = mk(4'b0000, 1, 0, 8'h94, 4'h0, 4'h0, 2'd1, 1, 1);
    vt[34] = mk(4'b0000, 1, 0, 8'h94, 4'h0, 4'h0, 2'd1, 0, 1);

    for (int i = 0; i < 35; i++) begin
      @(posedge clk);
      #1;
      man_gnt       = vt[i].gnt;
      bus.out_ready = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d", i), pk_dut(), pk_vec(vt[i]));
    end

    // Asynchronous reset in the middle of a burst
    @(posedge clk);
    #1;
    man_gnt       = 4'b0001;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    man_gnt = 4'b0000;
    chk("mid_burst_valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", pk_dut(), {11'b0, 1'b0, 8'h84, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0});
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle", {30'b0, bus.out_valid, bus.busy}, 32'd0);
    chk("post_reset_no_done", {28'b0, bus.done}, 32'd0);

    // Round-robin chain with the arbiter model
    @(negedge clk);
    idx_clr = 1'b1;
    @(negedge clk);
    idx_clr = 1'b0;
    arb_en  = 1'b1;
    ndone   = 0;
    for (int i = 0; i < 4; i++) begin
      beats[i] = 0;
      order[i] = -1;
      done_cyc[i] = 0;
    end
    for (int cyc = 0; cyc < 80 && ndone < 4; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.beat_take != 4'b0000) begin
        chk($sformatf("rr_beat_o%0d_b%0d", bus.owner, beats[bus.owner]),
            {24'b0, bus.out_data}, {24'b0, 8'h80 + 8'(16 * bus.owner) + 8'(beats[bus.owner])});
        beats[bus.owner]++;
      end
      if (bus.done != 4'b0000) begin
        order[ndone]    = int'(bus.owner);
        done_cyc[ndone] = cyc;
        ndone++;
      end
    end
    chk("rr_done_count", ndone, 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_order%0d", k), order[k], k);
      chk($sformatf("rr_beats%0d", k), beats[k], 32'd4);
    end
    for (int k = 1; k < 4; k++)
      chk($sformatf("rr_period%0d", k), done_cyc[k] - done_cyc[k-1], 32'd7);
    @(negedge clk);
    arb_en = 1'b0;

    // Single-beat burst
    @(posedge clk);
    #1;
    bus1.gnt = 4'b0010;
    @(posedge clk);
    #1;
    bus1.gnt = 4'b0000;
    chk("b1_xfer", {11'b0, bus1.out_valid, bus1.out_data, bus1.beat_take, bus1.done, bus1.owner, bus1.busy, bus1.err},
        {11'b0, 1'b1, 8'h22, 4'h2, 4'h0, 2'd1, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    chk("b1_done", {11'b0, bus1.out_valid, bus1.out_data, bus1.beat_take, bus1.done, bus1.owner, bus1.busy, bus1.err},
        {11'b0, 1'b0, 8'h22, 4'h0, 4'h2, 2'd1, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    chk("b1_cool", {28'b0, bus1.done, 1'b0, bus1.busy} , {28'b0, 4'h0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    chk("b1_idle", {30'b0, bus1.out_valid, bus1.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
